// File: rtl/cpu_pkg.sv
// Shared CPU-wide widths plus the write-back queue entry type.
package cpu_pkg;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_REGS = 32;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   word_t;

  typedef struct packed {
    logic      live;
    reg_addr_t rd;
    word_t     data;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_addr_t rd);
    reg_onehot     = '0;
    reg_onehot[rd] = 1'b1;
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// Circular queue of divider results with per-entry live bits that a younger
// pipeline write can clear by destination register.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  reg_addr_t                push_rd,
  input  word_t                    push_data,
  input  logic                     pop,
  input  logic                     squash_en,
  input  reg_addr_t                squash_rd,
  output logic                     head_valid,
  output logic                     head_live,
  output reg_addr_t                head_rd,
  output word_t                    head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [NUM_REGS-1:0]      live_mask
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [CW-1:0] CNT_ONE = 1;

  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;
  logic [CW-1:0] cnt;
  wb_entry_t     mem [DEPTH];

  // Squash is applied before the push so the entry written this cycle stays live;
  // popped slots are cleared so unoccupied entries never contribute to live_mask.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      cnt      <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i].live <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++)
        if (squash_en && mem[i].rd == squash_rd) mem[i].live <= 1'b0;
      if (pop) begin
        mem[head_ptr].live <= 1'b0;
        head_ptr           <= head_ptr + PTR_ONE;
      end
      if (push) begin
        mem[tail_ptr] <= '{live: 1'b1, rd: push_rd, data: push_data};
        tail_ptr      <= tail_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  assign head_valid = (cnt != '0);
  assign head_live  = mem[head_ptr].live;
  assign head_rd    = mem[head_ptr].rd;
  assign head_data  = mem[head_ptr].data;
  assign count      = cnt;

  always_comb begin
    live_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      if (mem[i].live) live_mask = live_mask | reg_onehot(mem[i].rd);
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline write-back has priority, divider
// results wait in wb_fifo and drain when the port is free.
module rf_wb_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pipe_wr_en,
  input  logic [REG_AW-1:0]      pipe_rd,
  input  logic [XLEN-1:0]        pipe_data,
  input  logic                   div_valid,
  output logic                   div_ready,
  input  logic [REG_AW-1:0]      div_rd,
  input  logic [XLEN-1:0]        div_data,
  output logic                   RFWr,
  output logic [REG_AW-1:0]      WrDtAdr,
  output logic [XLEN-1:0]        WrDt,
  output logic [NUM_REGS-1:0]    busy_mask,
  output logic [$clog2(DEPTH):0] q_count
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic      push;
  logic      pop;
  logic      pipe_write;
  logic      head_valid;
  logic      head_live;
  reg_addr_t head_rd;
  word_t     head_data;
  logic      wr_en;
  reg_addr_t wr_rd;
  word_t     wr_data;

  assign div_ready  = (q_count != FULL);
  assign push       = div_valid && div_ready && (div_rd != '0);
  assign pipe_write = pipe_wr_en && (pipe_rd != '0);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_rd    (div_rd),
    .push_data  (div_data),
    .pop        (pop),
    .squash_en  (pipe_write),
    .squash_rd  (pipe_rd),
    .head_valid (head_valid),
    .head_live  (head_live),
    .head_rd    (head_rd),
    .head_data  (head_data),
    .count      (q_count),
    .live_mask  (busy_mask)
  );

  // A pipeline request to x0 still owns the port, so the queue waits.
  always_comb begin
    wr_en   = 1'b0;
    wr_rd   = pipe_rd;
    wr_data = pipe_data;
    pop     = 1'b0;
    if (pipe_wr_en) begin
      wr_en = pipe_write;
    end else if (head_valid) begin
      pop     = 1'b1;
      wr_en   = head_live;
      wr_rd   = head_rd;
      wr_data = head_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      RFWr    <= 1'b0;
      WrDtAdr <= '0;
      WrDt    <= '0;
    end else begin
      RFWr <= wr_en;
      if (wr_en) begin
        WrDtAdr <= wr_rd;
        WrDt    <= wr_data;
      end
    end
  end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter (DEPTH=2) with hand-computed expectations.
module tb_rf_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_wr_en;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        div_valid;
  logic        div_ready;
  logic [4:0]  div_rd;
  logic [31:0] div_data;
  logic        RFWr;
  logic [4:0]  WrDtAdr;
  logic [31:0] WrDt;
  logic [31:0] busy_mask;
  logic [1:0]  q_count;

  int checks   = 0;
  int failures = 0;

  rf_wb_arbiter #(.DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .pipe_wr_en (pipe_wr_en),
    .pipe_rd    (pipe_rd),
    .pipe_data  (pipe_data),
    .div_valid  (div_valid),
    .div_ready  (div_ready),
    .div_rd     (div_rd),
    .div_data   (div_data),
    .RFWr       (RFWr),
    .WrDtAdr    (WrDtAdr),
    .WrDt       (WrDt),
    .busy_mask  (busy_mask),
    .q_count    (q_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe(input logic en, input logic [4:0] rd, input logic [31:0] d);
    pipe_wr_en = en; pipe_rd = rd; pipe_data = d;
  endtask

  task automatic div(input logic v, input logic [4:0] rd, input logic [31:0] d);
    div_valid = v; div_rd = rd; div_data = d;
  endtask

  task automatic expect_wr(input string tag, input logic wr, input logic [4:0] adr, input logic [31:0] d);
    check({tag, "_rfwr"}, {31'b0, RFWr}, {31'b0, wr});
    check({tag, "_adr"}, {27'b0, WrDtAdr}, {27'b0, adr});
    check({tag, "_data"}, WrDt, d);
  endtask

  task automatic expect_q(input string tag, input int cnt, input logic rdy, input logic [31:0] mask);
    check({tag, "_qcount"}, {30'b0, q_count}, cnt);
    check({tag, "_ready"}, {31'b0, div_ready}, {31'b0, rdy});
    check({tag, "_busy"}, busy_mask, mask);
  endtask

  initial begin
    rst = 1'b1;
    pipe(1'b1, 5'd5, 32'h0000_0055);
    div(1'b0, 5'd0, 32'h0);

    // Reset held with a pipeline request present
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_wr("reset", 1'b0, 5'd0, 32'h0);
      expect_q("reset", 0, 1'b1, 32'h0);
    end
    rst = 1'b0;
    tick();
    expect_wr("first_x5", 1'b1, 5'd5, 32'h0000_0055);
    pipe(1'b0, 5'd0, 32'h0);
    tick();
    expect_wr("hold_x5", 1'b0, 5'd5, 32'h0000_0055);

    // Simultaneous pipeline x3 and divider x7
    pipe(1'b1, 5'd3, 32'h1111_1111);
    div(1'b1, 5'd7, 32'h2222_2222);
    tick();
    pipe(1'b0, 5'd0, 32'h0);
    div(1'b0, 5'd0, 32'h0);
    expect_wr("pair_n1", 1'b1, 5'd3, 32'h1111_1111);
    expect_q("pair_n1", 1, 1'b1, 32'h0000_0080);
    tick();
    expect_wr("pair_n2", 1'b1, 5'd7, 32'h2222_2222);
    expect_q("pair_n2", 0, 1'b1, 32'h0);
    tick();
    check("pair_n3_rfwr", {31'b0, RFWr}, 32'd0);

    // Pipeline burst of 4 while divider offers x8, x9, x10
    pipe(1'b1, 5'd11, 32'h100);
    div(1'b1, 5'd8, 32'h808);
    tick();
    expect_wr("burst1", 1'b1, 5'd11, 32'h100);
    expect_q("burst1", 1, 1'b1, 32'h0000_0100);
    pipe(1'b1, 5'd12, 32'h101);
    div(1'b1, 5'd9, 32'h909);
    tick();
    expect_wr("burst2", 1'b1, 5'd12, 32'h101);
    expect_q("burst2", 2, 1'b0, 32'h0000_0300);
    pipe(1'b1, 5'd13, 32'h102);
    div(1'b1, 5'd10, 32'hA0A);
    tick();
    expect_wr("burst3", 1'b1, 5'd13, 32'h102);
    expect_q("burst3", 2, 1'b0, 32'h0000_0300);
    pipe(1'b1, 5'd14, 32'h103);
    tick();
    expect_wr("burst4", 1'b1, 5'd14, 32'h103);
    expect_q("burst4", 2, 1'b0, 32'h0000_0300);
    pipe(1'b0, 5'd0, 32'h0);
    tick();
    expect_wr("drain_x8", 1'b1, 5'd8, 32'h808);
    expect_q("drain_x8", 1, 1'b1, 32'h0000_0200);
    tick();
    div(1'b0, 5'd0, 32'h0);
    expect_wr("drain_x9", 1'b1, 5'd9, 32'h909);
    expect_q("drain_x9", 1, 1'b1, 32'h0000_0400);
    tick();
    expect_wr("drain_x10", 1'b1, 5'd10, 32'hA0A);
    expect_q("drain_x10", 0, 1'b1, 32'h0);
    tick();
    check("drain_idle_rfwr", {31'b0, RFWr}, 32'd0);

    // WAW squash: queued x4 overwritten by younger pipeline x4
    div(1'b1, 5'd4, 32'hAAAA);
    tick();
    div(1'b0, 5'd0, 32'h0);
    expect_wr("waw_q", 1'b0, 5'd10, 32'hA0A);
    expect_q("waw_q", 1, 1'b1, 32'h0000_0010);
    pipe(1'b1, 5'd4, 32'hBBBB);
    tick();
    pipe(1'b0, 5'd0, 32'h0);
    expect_wr("waw_pipe", 1'b1, 5'd4, 32'hBBBB);
    expect_q("waw_pipe", 1, 1'b1, 32'h0);
    tick();
    expect_wr("waw_deadpop", 1'b0, 5'd4, 32'hBBBB);
    expect_q("waw_deadpop", 0, 1'b1, 32'h0);

    // x0 from both sources: no write, nothing queued
    pipe(1'b1, 5'd0, 32'hDEAD);
    div(1'b1, 5'd0, 32'hBEEF);
    tick();
    pipe(1'b0, 5'd0, 32'h0);
    div(1'b0, 5'd0, 32'h0);
    expect_wr("x0_both", 1'b0, 5'd4, 32'hBBBB);
    expect_q("x0_both", 0, 1'b1, 32'h0);

    // Pipeline x0 request still blocks the queue head
    div(1'b1, 5'd6, 32'h6666);
    tick();
    div(1'b0, 5'd0, 32'h0);
    pipe(1'b1, 5'd0, 32'h1234);
    tick();
    pipe(1'b0, 5'd0, 32'h0);
    expect_wr("x0_block", 1'b0, 5'd4, 32'hBBBB);
    expect_q("x0_block", 1, 1'b1, 32'h0000_0040);
    tick();
    expect_wr("x0_release", 1'b1, 5'd6, 32'h6666);
    expect_q("x0_release", 0, 1'b1, 32'h0);

    // Reset with two live entries queued
    pipe(1'b1, 5'd20, 32'h2020);
    div(1'b1, 5'd21, 32'h2121);
    tick();
    pipe(1'b1, 5'd22, 32'h2222);
    div(1'b1, 5'd23, 32'h2323);
    tick();
    expect_q("prerst", 2, 1'b0, 32'h00A0_0000);
    pipe(1'b0, 5'd0, 32'h0);
    div(1'b0, 5'd0, 32'h0);
    rst = 1'b1;
    tick();
    expect_wr("midrst", 1'b0, 5'd0, 32'h0);
    expect_q("midrst", 0, 1'b1, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_wr("postrst", 1'b0, 5'd0, 32'h0);
      expect_q("postrst", 0, 1'b1, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter driving the register-file write port. Merges the in-order pipeline write-back stream with out-of-order results from the multi-cycle divider, issues at most one RF write per cycle, and buffers divider results while the pipeline holds the port. Sits between the WB stage / divider and the register file. It also exports a busy mask of registers with pending divider writes so the hazard unit can stall dependent reads.

## Interface
- DEPTH, 2, divider result queue entries (power of two, ≥2)
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous active-high reset
- pipe_wr_en  in  1  pipeline write-back request this cycle (cannot be stalled)
- pipe_rd  in  5  pipeline destination register
- pipe_data  in  32  pipeline write data
- div_valid  in  1  divider result valid
- div_ready  out  1  queue can accept a divider result
- div_rd  in  5  divider destination register
- div_data  in  32  divider result
- RFWr  out  1  register-file write enable (registered)
- WrDtAdr  out  5  register-file write address (registered)
- WrDt  out  32  register-file write data (registered)
- busy_mask  out  32  bit r set while a live queued divider write targets xr
- q_count  out  $clog2(DEPTH)+1  live-or-dead occupied queue entries

## Operation
- Divider handshake: result accepted when div_valid && div_ready; div_ready = (q_count != DEPTH). Accepted result with div_rd == 0 is consumed and discarded (not enqueued).
- Queue: circular FIFO, entries {live, rd, data}; push at tail on accept, pop at head.
- Per-cycle selection, priority order:
  1. pipe_wr_en && pipe_rd != 0: write pipeline data; queue does not pop.
  2. else head entry exists and live: write head data; pop.
  3. else head entry exists and dead: pop, no write.
  4. else no write.
- pipe_wr_en with pipe_rd == 0: no write issued, but port still counts as taken (queue does not pop that cycle).
- Squash (WAW): a pipeline write to rd clears live on every queued entry with matching rd (pipeline write is younger). Entry being pushed the same cycle with the same rd is NOT squashed (divider result is younger).
- Simultaneous push and pop permitted; q_count unchanged.
- busy_mask: OR over live entries of one-hot(rd); combinational from queue state, excludes the result being accepted this cycle.
- Reset: RFWr=0, WrDtAdr=0, WrDt=0, queue empty, q_count=0, busy_mask=0, div_ready=1 after reset release. Reset mid-operation discards all queued results.

## Timing
- Pipeline write requested at cycle N -> RFWr/WrDtAdr/WrDt valid during N+1 (RF samples on negedge of N+1).
- Divider result accepted at N -> enqueued at N+1 -> earliest RFWr at N+2; each cycle of pipeline writes delays it one cycle.
- RFWr high for exactly one cycle per write; WrDtAdr/WrDt hold last value when RFWr=0.
- Full queue: div_ready low the same cycle q_count==DEPTH; reasserts the cycle after a pop.
- Pointers wrap modulo DEPTH.

## Structure
- Shared package cpu_pkg: XLEN=32, REG_AW=5, NUM_REGS=32.
- One sub-module wb_fifo (parameter DEPTH): storage, pointers, count, per-entry live bits with squash-by-rd port; arbiter logic and output registers in rf_wb_arbiter.

## Test plan
- Reset with pipe_wr_en=1, pipe_rd=5 held: RFWr=0 throughout reset, q_count=0, div_ready=1; first write x5 one cycle after release.
- Pipeline write x3=0x11111111 at N, divider result x7=0x22222222 accepted at N: N+1 writes x3, N+2 writes x7; busy_mask bit7 set during N+1 only.
- Pipeline writes every cycle for 4 cycles while divider offers x8, x9, x10: div_ready drops after 2 accepts, q_count=2, both written in order x8, x9 immediately after pipeline burst ends, then x10 accepted.
- Divider x4=0xAAAA queued, pipeline writes x4=0xBBBB next cycle: only 0xBBBB reaches RF; dead entry popped without RFWr; busy_mask bit4 clears.
- Writes to x0 from either source: no RFWr pulse, divider x0 result never occupies queue.
- Reset asserted with 2 entries queued: queue emptied, no write of either entry after release.
